mot_seq: RTL and testbench

Motion-command sequencer between the PicoBlaze I/O interface and the RojoBot. Firmware queues (motor-control, duration) pairs into an internal FIFO. The block applies each command to the bot's MotCtl input and holds it for the requested number of `upd_sysregs` update ticks, then advances to the next command. When the queue drains it returns the bot to stop (8'h00) and raises a one-cycle done pulse that the I/O interface can route to the CPU interrupt.

---
 rtl/mot_seq.sv | 135 +++++++++++++
 tb/tb_mot_seq.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mot_seq.sv
// mot_seq: motion-command sequencer feeding RojoBot MotCtl.
// Ports: clk/reset, wr_* push, enable/abort/ovf_clr/upd_sysregs; motctl, busy, done, full/empty/count, ovf.
module mot_seq #(
  parameter int DEPTH = 8,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_motctl,
  input  logic [7:0]    wr_ticks,
  input  logic          enable,
  input  logic          abort,
  input  logic          ovf_clr,
  input  logic          upd_sysregs,
  output logic [7:0]    motctl,
  output logic          busy,
  output logic          done,
  output logic          full,
  output logic          empty,
  output logic [PW:0]   count,
  output logic          ovf
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [PW:0] ONE = (PW+1)'(1);

  state_t        r_state;
  logic [15:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  logic [7:0]    r_rem;
  logic [7:0]    r_motctl;
  logic          r_ovf;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic [15:0]   w_head;

  assign w_full  = (r_count == (PW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  // abort swallows a same-cycle write entirely
  assign w_push  = wr_en & ~w_full & ~abort;
  assign w_drop  = wr_en &  w_full & ~abort;
  assign w_pop   = (r_state == S_LOAD) & ~abort;
  assign w_head  = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {wr_motctl, wr_ticks};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (abort) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + ONE;
      else if (!w_push && w_pop)
        r_count <= r_count - ONE;
    end
  end

  // a drop in the same cycle as a clear keeps ovf set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_ovf <= 1'b0;
    else        r_ovf <= w_drop | (r_ovf & ~ovf_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_motctl <= '0;
      r_rem    <= '0;
    end else if (abort) begin
      r_state  <= S_IDLE;
      r_motctl <= '0;
      r_rem    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (enable && !w_empty) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_motctl <= w_head[15:8];
          r_rem    <= w_head[7:0];
          r_state  <= S_RUN;
        end
        S_RUN: begin
          // the pulse that zeroes rem is consumed here
          if (r_rem != '0) begin
            if (upd_sysregs) r_rem <= r_rem - 8'd1;
          end else if (enable && !w_empty) begin
            r_state <= S_LOAD;
          end else begin
            r_motctl <= '0;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign motctl = r_motctl;
  assign busy   = (r_state == S_LOAD) || (r_state == S_RUN);
  assign done   = (r_state == S_DONE);
  assign full   = w_full;
  assign empty  = w_empty;
  assign count  = r_count;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_mot_seq.sv
// tb_mot_seq: directed plus random checks of mot_seq
// against a queue-based reference model.
module tb_mot_seq;
  localparam int DEPTH = 8;
  localparam int PW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wr_en = 1'b0;
  logic [7:0] wr_motctl = '0;
  logic [7:0] wr_ticks = '0;
  logic enable = 1'b0;
  logic abort = 1'b0;
  logic ovf_clr = 1'b0;
  logic upd_sysregs = 1'b0;
  logic [7:0] motctl;
  logic busy, done, full, empty, ovf;
  logic [PW:0] count;

  int n_tot = 0;
  int n_bad = 0;

  mot_seq #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_motctl(wr_motctl),
    .wr_ticks(wr_ticks), .enable(enable),
    .abort(abort), .ovf_clr(ovf_clr),
    .upd_sysregs(upd_sysregs),
    .motctl(motctl), .busy(busy),
    .done(done), .full(full),
    .empty(empty), .count(count),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] m;
    logic [7:0] t;
  } cmd_t;

  cmd_t q[$];
  int ph;
  int left;
  logic [7:0] mm;
  logic ov;

  logic [7:0] seq[$];
  logic [7:0] obs[$];
  logic [7:0] t2_exp [4];
  logic [7:0] last;
  int pulses, p3, dcyc, dn, run22, nxt;
  bit seen_done;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    ph = 0;
    left = 0;
    mm = 8'h00;
    ov = 1'b0;
  endfunction

  // ph: 0 idle, 1 fetching, 2 holding, 3 finished
  function automatic void model_edge();
    bit was_full;
    bit has;
    bit pop;
    was_full = (q.size() == DEPTH);
    has = (q.size() != 0);
    pop = 1'b0;
    ov = (wr_en && was_full && !abort) || (ov && !ovf_clr);
    if (abort) begin
      q.delete();
      ph = 0;
      mm = 8'h00;
      left = 0;
      return;
    end
    case (ph)
      0: if (enable && has) ph = 1;
      1: begin
        mm = q[0].m;
        left = int'(q[0].t);
        pop = 1'b1;
        ph = 2;
      end
      2: begin
        if (left != 0) begin
          if (upd_sysregs) left--;
        end else if (enable && has) begin
          ph = 1;
        end else begin
          mm = 8'h00;
          ph = 3;
        end
      end
      default: ph = 0;
    endcase
    if (pop) void'(q.pop_front());
    if (wr_en && !was_full)
      q.push_back(cmd_t'({wr_motctl, wr_ticks}));
  endfunction

  task automatic check_outs();
    chk("motctl", 32'(motctl), 32'(mm));
    chk("busy", 32'(busy), 32'(ph == 1 || ph == 2));
    chk("done", 32'(done), 32'(ph == 3));
    chk("count", 32'(count), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("ovf", 32'(ovf), 32'(ov));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outs();
  endtask

  task automatic push(input logic [7:0] m,
                      input logic [7:0] t);
    wr_en = 1'b1;
    wr_motctl = m;
    wr_ticks = t;
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      step();
      k++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_motctl"}, 32'(motctl), 32'h00);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t", $time);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    t2_exp = '{8'h11, 8'h22, 8'h44, 8'h00};
    model_reset();
    #2 reset = 1'b0;
    #20;
    chk_reset_vals("rst");
    reset = 1'b1;

    // single command, pulse every 10 cycles
    push(8'h33, 8'd3);
    enable = 1'b1;
    step();
    step();
    chk("t1_motctl", 32'(motctl), 32'h33);
    pulses = 0; p3 = -1; dcyc = -1; dn = 0;
    for (int c = 0; c < 60; c++) begin
      upd_sysregs = (c % 10 == 9);
      step();
      if (upd_sysregs) begin
        pulses++;
        if (pulses == 3) p3 = c;
      end
      if (done) begin
        dn++;
        dcyc = c;
        chk("t1_stop", 32'(motctl), 32'h00);
      end
    end
    upd_sysregs = 1'b0;
    chk("t1_done_cnt", dn, 1);
    chk("t1_done_lat", dcyc - p3, 1);

    // chained commands
    enable = 1'b0;
    push(8'h11, 8'd1);
    push(8'h22, 8'd0);
    push(8'h44, 8'd2);
    enable = 1'b1;
    last = motctl; dn = 0; run22 = 0;
    seq.delete();
    for (int c = 0; c < 40; c++) begin
      upd_sysregs = (c % 3 == 2);
      step();
      if (motctl != last) seq.push_back(motctl);
      last = motctl;
      if (motctl == 8'h22) run22++;
      if (done) dn++;
    end
    upd_sysregs = 1'b0;
    chk("t2_len", seq.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < seq.size())
        chk("t2_seq", 32'(seq[i]), 32'(t2_exp[i]));
    chk("t2_hold22", run22, 2);
    chk("t2_done_cnt", dn, 1);

    // overflow
    enable = 1'b0;
    for (int i = 0; i < 9; i++)
      push(8'($urandom), 8'($urandom_range(0, 5)));
    chk("t3_count", 32'(count), DEPTH);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_ovf", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("t3_ovf_clr", 32'(ovf), 32'd0);
    enable = 1'b1;
    upd_sysregs = 1'b1;
    wait_done(200);
    upd_sysregs = 1'b0;
    enable = 1'b0;
    step();

    // abort with a same-cycle write
    push(8'h55, 8'd200);
    enable = 1'b1;
    step();
    step();
    chk("t4_run", 32'(motctl), 32'h55);
    step();
    abort = 1'b1;
    wr_en = 1'b1;
    wr_motctl = 8'h99;
    wr_ticks = 8'd1;
    step();
    abort = 1'b0;
    wr_en = 1'b0;
    chk("t4_motctl", 32'(motctl), 32'h00);
    chk("t4_count", 32'(count), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_nodone", 32'(done), 32'd0);
    end

    // push during pop at DEPTH-1, then wrap
    enable = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++)
      push(8'(8'h80 + i), 8'd1);
    enable = 1'b1;
    step();
    wr_en = 1'b1;
    wr_motctl = 8'(8'h80 + DEPTH - 1);
    wr_ticks = 8'd1;
    step();
    wr_en = 1'b0;
    chk("t5_cnt", 32'(count), DEPTH - 1);
    obs.delete();
    obs.push_back(motctl);
    last = motctl;
    nxt = DEPTH;
    seen_done = 1'b0;
    upd_sysregs = 1'b1;
    for (int c = 0; c < 400 && !seen_done; c++) begin
      wr_en = (nxt < 3 * DEPTH) && (q.size() < DEPTH);
      wr_motctl = 8'(8'h80 + nxt);
      wr_ticks = 8'd1;
      step();
      if (wr_en) nxt++;
      if (motctl != last && motctl != 8'h00)
        obs.push_back(motctl);
      last = motctl;
      if (done) seen_done = 1'b1;
    end
    wr_en = 1'b0;
    upd_sysregs = 1'b0;
    chk("t5_done", 32'(seen_done), 32'd1);
    chk("t5_len", obs.size(), 3 * DEPTH);
    for (int i = 0; i < obs.size(); i++)
      chk("t5_order", 32'(obs[i]), 32'(8'(8'h80 + i)));

    // random traffic
    enable = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      wr_en = ($urandom_range(0, 9) < 4);
      wr_motctl = 8'($urandom);
      wr_ticks = 8'($urandom_range(0, 4));
      upd_sysregs = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 99) == 0);
      ovf_clr = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      step();
    end
    wr_en = 1'b0;
    upd_sysregs = 1'b0;
    ovf_clr = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;

    // asynchronous reset mid-run
    enable = 1'b0;
    push(8'h77, 8'd50);
    enable = 1'b1;
    step();
    step();
    chk("t7_run", 32'(motctl), 32'h77);
    #3 reset = 1'b0;
    #1;
    chk_reset_vals("t7");
    model_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    enable = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
